// File: rtl/encoder_scheduler_if.sv
// ---------------------------------------------------------------------------
// encoder_scheduler_if
//   Bundles the requester side and the encoder side of encoder_scheduler.
//
//   Parameters
//     NUM_REQ    : number of frame sources
//     FRAME_SIZE : encoder frame width (matches FRAME_SIZE in definitions.v)
//
//   Signals
//     req_valid  : per-requester frame request (level)
//     req_data   : packed frames, requester i at [i*FRAME_SIZE +: FRAME_SIZE]
//     req_ack    : one-cycle completion pulse to the served requester
//     enc_data   : frame presented to encoder data
//     enc_enable : encoder enable
//     enc_irq    : encoder completion flag
//     busy       : scheduler not idle
//     grant_id   : current or last granted requester
//     tx_error   : one-cycle watchdog abort pulse
//
//   Modports
//     master : requesters + encoder (drive requests and irq)
//     slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface encoder_scheduler_if #(
   parameter int NUM_REQ    = 4,
   parameter int FRAME_SIZE = 16
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*FRAME_SIZE-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ack;
   logic [FRAME_SIZE-1:0]         enc_data;
   logic                          enc_enable;
   logic                          enc_irq;
   logic                          busy;
   logic [IDW-1:0]                grant_id;
   logic                          tx_error;

   modport master (
      output req_valid, req_data, enc_irq,
      input  req_ack, enc_data, enc_enable, busy, grant_id, tx_error
   );

   modport slave (
      input  req_valid, req_data, enc_irq,
      output req_ack, enc_data, enc_enable, busy, grant_id, tx_error
   );
endinterface

// File: rtl/encoder_scheduler.sv
// ---------------------------------------------------------------------------
// encoder_scheduler
//   Shares one LightIO encoder among NUM_REQ frame sources. Round-robin
//   arbitration in IDLE, holds the granted frame on the encoder for the
//   whole transfer, waits for enc_irq, then enforces an inter-frame gap that
//   also waits for enc_irq to drop.
//
//   Optional feature macro: ENC_WATCHDOG_EN
//     defined   : BUSY aborts after TIMEOUT_CYCLES without enc_irq and
//                 pulses tx_error (no req_ack for the aborted frame)
//     undefined : BUSY waits indefinitely, tx_error tied 0
//
//   Ports
//     clock : system clock, rising edge
//     reset : asynchronous, active-low
//     bus   : encoder_scheduler_if.slave (requests, acks, encoder drive)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no frame in flight, arbitrate among req_valid
//   BUSY  | enc_enable high with latched frame, wait for enc_irq
//   GAP   | enc_enable low, count GAP_CYCLES and wait for enc_irq low
// ---------------------------------------------------------------------------
module encoder_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int FRAME_SIZE     = 16
) (
   input logic               clock,
   input logic               reset,
   encoder_scheduler_if.slave bus
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int GCW = $clog2(GAP_CYCLES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]            state;
   logic [IDW-1:0]        grant_q;     // doubles as the round-robin pointer
   logic [FRAME_SIZE-1:0] enc_data_q;
   logic                  enc_enable_q;
   logic [NUM_REQ-1:0]    req_ack_q;
   logic [GCW-1:0]        gap_cnt;

   logic                  any_req;
   logic [IDW-1:0]        winner;
   logic                  wd_expire;

   // First set request bit searching upward from pointer+1, wrapping.
   always_comb begin
      int idx;
      any_req = 1'b0;
      winner  = '0;
      idx     = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(grant_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any_req && bus.req_valid[idx]) begin
            any_req = 1'b1;
            winner  = IDW'(idx);
         end
      end
   end

`ifdef ENC_WATCHDOG_EN
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TCW-1:0] wd_cnt;
   logic           tx_error_q;

   // wd_cnt holds k-1 on the k-th BUSY edge, so the abort lands exactly
   // TIMEOUT_CYCLES edges after the grant.
   assign wd_expire = (state == S_BUSY) && (wd_cnt == TCW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
      end else if (state == S_IDLE) begin
         wd_cnt <= '0;
      end else if (state == S_BUSY && wd_cnt != '1) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // enc_irq on the expiry edge wins, so no error in that case.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_error_q <= 1'b0;
      end else begin
         tx_error_q <= wd_expire && !bus.enc_irq;
      end
   end

   assign bus.tx_error = tx_error_q;
`else
   assign wd_expire    = 1'b0;
   assign bus.tx_error = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         grant_q      <= IDW'(NUM_REQ - 1);
         enc_data_q   <= '0;
         enc_enable_q <= 1'b0;
         req_ack_q    <= '0;
         gap_cnt      <= '0;
      end else begin
         req_ack_q <= '0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  grant_q      <= winner;
                  enc_data_q   <= bus.req_data[int'(winner)*FRAME_SIZE +: FRAME_SIZE];
                  enc_enable_q <= 1'b1;
                  state        <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (bus.enc_irq) begin
                  req_ack_q[grant_q] <= 1'b1;
                  enc_enable_q       <= 1'b0;
                  gap_cnt            <= GCW'(GAP_CYCLES - 1);
                  state              <= S_GAP;
               end else if (wd_expire) begin
                  enc_enable_q <= 1'b0;
                  gap_cnt      <= GCW'(GAP_CYCLES - 1);
                  state        <= S_GAP;
               end
            end
            S_GAP: begin
               // Loaded with GAP_CYCLES-1 so the last GAP edge is the one
               // that sees zero; an asserted irq holds us here regardless.
               if (gap_cnt == '0) begin
                  if (!bus.enc_irq) state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               state        <= S_IDLE;
               enc_enable_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ack    = req_ack_q;
   assign bus.enc_data   = enc_data_q;
   assign bus.enc_enable = enc_enable_q;
   assign bus.busy       = (state != S_IDLE);
   assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_encoder_scheduler.sv
// ---------------------------------------------------------------------------
// tb_encoder_scheduler
//   Directed bench for encoder_scheduler (NUM_REQ=4, GAP_CYCLES=8,
//   TIMEOUT_CYCLES=16, FRAME_SIZE=16). Watchdog steps are built only when
//   ENC_WATCHDOG_EN is defined.
// ---------------------------------------------------------------------------
module tb_encoder_scheduler;
   localparam int NREQ = 4;
   localparam int GAP  = 8;
   localparam int FS   = 16;

   logic clock;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   logic [FS-1:0] frame [NREQ];

   encoder_scheduler_if #(.NUM_REQ(NREQ), .FRAME_SIZE(FS)) bus ();

   encoder_scheduler #(
      .NUM_REQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16), .FRAME_SIZE(FS)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

   initial begin
      frame[0] = 16'hA0A0;
      frame[1] = 16'h4FB6;
      frame[2] = 16'h1234;
      frame[3] = 16'hBEEF;
      reset         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = {frame[3], frame[2], frame[1], frame[0]};
      bus.enc_irq   = 1'b0;
      #12;
      chk("rst_enable", 32'(bus.enc_enable), 0);
      chk("rst_data",   32'(bus.enc_data),   0);
      chk("rst_ack",    32'(bus.req_ack),    0);
      chk("rst_busy",   32'(bus.busy),       0);
      chk("rst_txerr",  32'(bus.tx_error),   0);
      chk("rst_grant",  32'(bus.grant_id),   3);
      @(posedge clock);
      #1 reset = 1'b1;

      // single request from requester 1
      bus.req_valid = 4'b0010;
      tick();
      chk("single_data",   32'(bus.enc_data),   32'h4FB6);
      chk("single_enable", 32'(bus.enc_enable), 1);
      chk("single_grant",  32'(bus.grant_id),   1);
      chk("single_busy",   32'(bus.busy),       1);
      bus.req_valid = '0;
      repeat (3) tick();
      chk("hold_enable", 32'(bus.enc_enable), 1);
      chk("hold_data",   32'(bus.enc_data),   32'h4FB6);
      chk("hold_ack",    32'(bus.req_ack),    0);
      chk("hold_txerr",  32'(bus.tx_error),   0);
      bus.enc_irq = 1'b1;
      tick();
      chk("single_ack",     32'(bus.req_ack),    32'h2);
      chk("single_en_off",  32'(bus.enc_enable), 0);
      chk("single_gapbusy", 32'(bus.busy),       1);
      bus.enc_irq = 1'b0;
      tick();
      chk("single_ack_end", 32'(bus.req_ack), 0);
      repeat (6) tick();
      chk("gap_last_busy", 32'(bus.busy), 1);
      tick();
      chk("gap_done_idle", 32'(bus.busy), 0);
      chk("gap_data_kept", 32'(bus.enc_data), 32'h4FB6);

      // irq in IDLE is ignored
      bus.enc_irq = 1'b1;
      repeat (3) tick();
      chk("idle_irq_busy", 32'(bus.busy),    0);
      chk("idle_irq_ack",  32'(bus.req_ack), 0);
      bus.enc_irq = 1'b0;

      // round-robin from reset with all requesters pending
      reset = 1'b0;
      bus.req_valid = 4'b1111;
      tick();
      reset = 1'b1;
      tick();
      for (int k = 0; k < NREQ; k++) begin
         chk("rr_grant",  32'(bus.grant_id),   32'(k));
         chk("rr_enable", 32'(bus.enc_enable), 1);
         chk("rr_data",   32'(bus.enc_data),   32'(frame[k]));
         repeat (2) tick();
         bus.enc_irq = 1'b1;
         tick();
         chk("rr_ack", 32'(bus.req_ack), 32'(1 << k));
         bus.enc_irq = 1'b0;
         repeat (GAP) tick();
         chk("rr_gap_enable", 32'(bus.enc_enable), 0);
         chk("rr_gap_idle",   32'(bus.busy),       0);
         tick();
      end
      chk("rr_wrap_grant", 32'(bus.grant_id), 0);
      chk("rr_wrap_data",  32'(bus.enc_data), 32'hA0A0);

      // gap/irq interlock: irq held 12 cycles after completion
      repeat (2) tick();
      bus.enc_irq = 1'b1;
      tick();
      chk("lock_ack", 32'(bus.req_ack), 32'h1);
      repeat (9) tick();
      chk("lock_m9_busy",   32'(bus.busy),       1);
      chk("lock_m9_enable", 32'(bus.enc_enable), 0);
      repeat (2) tick();
      chk("lock_m11_busy", 32'(bus.busy), 1);
      bus.enc_irq = 1'b0;
      tick();
      chk("lock_release_idle", 32'(bus.busy), 0);
      tick();
      chk("lock_next_grant",  32'(bus.grant_id),   1);
      chk("lock_next_enable", 32'(bus.enc_enable), 1);

      // reset 5 cycles into BUSY
      repeat (5) tick();
      #2 reset = 1'b0;
      #1;
      chk("midrst_enable", 32'(bus.enc_enable), 0);
      chk("midrst_busy",   32'(bus.busy),       0);
      chk("midrst_ack",    32'(bus.req_ack),    0);
      chk("midrst_grant",  32'(bus.grant_id),   3);
      chk("midrst_data",   32'(bus.enc_data),   0);
      #1 reset = 1'b1;
      tick();
      chk("post_rst_grant",  32'(bus.grant_id),   0);
      chk("post_rst_enable", 32'(bus.enc_enable), 1);
      bus.req_valid = '0;
      bus.enc_irq = 1'b1;
      tick();
      chk("post_rst_ack", 32'(bus.req_ack), 32'h1);
      bus.enc_irq = 1'b0;
      repeat (GAP) tick();
      chk("post_rst_idle", 32'(bus.busy), 0);

`ifdef ENC_WATCHDOG_EN
      // watchdog abort on requester 2, then race on requester 3
      bus.req_valid = 4'b1100;
      tick();
      chk("wd_grant", 32'(bus.grant_id), 2);
      repeat (15) tick();
      chk("wd_pre_txerr",  32'(bus.tx_error),   0);
      chk("wd_pre_enable", 32'(bus.enc_enable), 1);
      tick();
      chk("wd_txerr",  32'(bus.tx_error),   1);
      chk("wd_noack",  32'(bus.req_ack),    0);
      chk("wd_enable", 32'(bus.enc_enable), 0);
      tick();
      chk("wd_txerr_end", 32'(bus.tx_error), 0);
      chk("wd_noack2",    32'(bus.req_ack),  0);
      repeat (7) tick();
      tick();
      chk("wd_next_grant", 32'(bus.grant_id), 3);
      repeat (15) tick();
      bus.enc_irq = 1'b1;
      tick();
      chk("race_ack",   32'(bus.req_ack),  32'h8);
      chk("race_txerr", 32'(bus.tx_error), 0);
      bus.enc_irq = 1'b0;
      bus.req_valid = '0;
      tick();
      chk("race_txerr2", 32'(bus.tx_error), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/encoder_scheduler.md
# encoder_scheduler

Transmit scheduler sharing one LightIO `encoder` among several frame sources. Arbitrates round-robin between requesters, latches the winner's frame, drives the encoder's `data`/`enable` inputs for one frame, waits for the encoder's `irq` completion flag and then enforces an inter-frame gap. Sits directly upstream of `encoder`; the encoder's `led` output is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `GAP_CYCLES`, 8: idle cycles between frames, ≥1.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles. Used only with `ENC_WATCHDOG_EN`.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `req_valid` in NUM_REQ: per-requester frame request, level.
- `req_data` in NUM_REQ*`FRAME_SIZE`: packed frames. Requester i uses bits [i*`FRAME_SIZE` +: `FRAME_SIZE`]. `FRAME_SIZE` comes from `definitions.v`.
- `req_ack` out NUM_REQ: one-cycle pulse to the requester whose frame completed.
- `enc_data` out `FRAME_SIZE`: to encoder `data`.
- `enc_enable` out 1: to encoder `enable`.
- `enc_irq` in 1: from encoder `irq`; high means the frame is done.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out $clog2(NUM_REQ): index of the current or last granted requester.
- `tx_error` out 1: one-cycle pulse on watchdog abort. Tied 0 when the watchdog is compiled out.

## Operation
- States: IDLE, BUSY, GAP.
- Reset values: state IDLE, `enc_enable`=0, `enc_data`=0, `req_ack`=0, `busy`=0, `tx_error`=0, `grant_id`=NUM_REQ-1. The round-robin pointer is NUM_REQ-1, so requester 0 has first priority.
- IDLE: if any `req_valid` bit is high, the winner is the first set bit, searching upward from pointer+1 and wrapping modulo NUM_REQ.
  - Latch the winner's frame into `enc_data`.
  - Set `grant_id` and the pointer to the winner.
  - Set `enc_enable`=1 and go to BUSY.
- BUSY:
  - `enc_data` and `enc_enable` are held stable.
  - `req_valid` and `req_data` are ignored, so dropping `req_valid` after grant does not abort the frame.
  - When `enc_irq`=1: pulse `req_ack[grant_id]`, clear `enc_enable` and go to GAP.
- GAP:
  - Count GAP_CYCLES cycles with `enc_enable`=0.
  - Return to IDLE only when the count has expired and `enc_irq`=0. Otherwise stay in GAP.
  - `enc_data` keeps its last value.
- Requester contract: hold `req_valid` high with stable `req_data` until the cycle after grant. A requester that keeps `req_valid` high after its `req_ack` is re-queued behind the others.
- `enc_irq` is ignored in IDLE.
- Arbitration is evaluated only in IDLE. Requests arriving in BUSY or GAP wait there.
- Reset asserted mid-frame: all outputs return to their reset values asynchronously and no `req_ack` is issued. The encoder sees `enable` drop immediately.

## Timing
- `req_valid` sampled high at edge N, with the scheduler in IDLE: `enc_enable`=1, `enc_data`, `grant_id` and `busy` are valid after edge N.
- `enc_irq` sampled high at edge M, in BUSY:
  - `req_ack` is high and `enc_enable` is 0 for cycle M→M+1.
  - `req_ack` returns to 0 after edge M+1.
- GAP occupies edges M+1 … M+GAP_CYCLES. The earliest next grant is at edge M+GAP_CYCLES+1.
- Back-to-back frame period = encoder frame time + GAP_CYCLES + 1 cycles.
- The gap counter is $clog2(GAP_CYCLES+1) bits wide and saturates.

## Configuration
- `ENC_WATCHDOG_EN` defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entering BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without `enc_irq`: clear `enc_enable`, pulse `tx_error` for one cycle, issue no `req_ack`, go to GAP.
  - The pointer still advances, so the failing requester loses priority.
  - If `enc_irq` and timeout occur in the same cycle, `enc_irq` wins and `req_ack` is issued.
- `ENC_WATCHDOG_EN` undefined: no counter is built, BUSY waits indefinitely, and `tx_error` is constant 0.

## Test plan
- Single request: `req_valid`=4'b0010 with frame 16'h4FB6. Required: `enc_data`=16'h4FB6, `enc_enable`=1 and `grant_id`=1 one edge later. After `enc_irq` is raised, `req_ack`=4'b0010 for exactly one cycle.
- Round-robin: all four requesters held high from reset. Required grant order 0,1,2,3,0. Each grant is separated from the prior `enc_irq` by exactly GAP_CYCLES+1 cycles.
- Gap and irq interlock: GAP_CYCLES=8 with `enc_irq` held high for 12 cycles after completion. Required: the next grant is delayed until `enc_irq` falls, not at cycle 9.
- Reset mid-frame: pull `reset` low 5 cycles into BUSY. Required: `enc_enable`=0, `busy`=0 and `req_ack`=0 with no clock edge needed. After release, requester 0 is granted first.
- Watchdog (`ENC_WATCHDOG_EN`, TIMEOUT_CYCLES=16): `enc_irq` never raised on requester 2's frame. Required:
  - `tx_error` pulses 16 cycles after the grant.
  - No `req_ack`.
  - Requester 3 is granted next if pending.
- Watchdog race: `enc_irq` raised exactly on cycle 16. Required: `req_ack` pulses and `tx_error` stays 0.
